ravan_stream_core: RTL and testbench

RAVAN_STREAM_CORE -- requirements
Module: ravan_stream_core

---
 rtl/ravan_stream_core.sv | 151 +++++++++++++++
 tb/tb_ravan_stream_core.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ravan_stream_core.sv
// Iterated add-rotate block cipher with an on-chip round-key schedule and valid/ready streaming.
// Build option: define RAVAN_KEY_CHECK_EN to reject the all-zero key and raise a sticky key_error.
module ravan_stream_core #(
  parameter int DATA_W = 64,
  parameter int KEY_W  = 512,
  parameter int ROUNDS = 8,
  parameter int ROT    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [KEY_W-1:0]  key,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_mode,
  output logic              busy,
  output logic              key_error
);
  localparam int CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

  typedef enum logic [2:0] {IDLE, KEYSCHED, READY, BUSY, DONE} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_mode_q;
  logic [KEY_W-1:0]  key_q;
  logic [DATA_W-1:0] rk_q [ROUNDS];
  logic [DATA_W-1:0] x_q;
  logic [DATA_W-1:0] x_d;
  logic              mode_q;
  logic [CNT_W-1:0]  ridx;
  logic              key_hs;
  logic              in_hs;
  logic              key_bad;

  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] v);
    return (v << ROT) | (v >> (DATA_W - ROT));
  endfunction

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] v);
    return (v >> ROT) | (v << (DATA_W - ROT));
  endfunction

  // Rotating the key right by one word each schedule cycle presents word (i mod N) at the bottom.
  function automatic logic [KEY_W-1:0] key_rot(input logic [KEY_W-1:0] v);
    return (v >> DATA_W) | (v << (KEY_W - DATA_W));
  endfunction

  assign key_ready = (state_q == IDLE) || (state_q == READY);
  assign in_ready  = (state_q == READY) && !key_valid;
  assign busy      = (state_q != IDLE) && (state_q != READY);
  assign key_hs    = key_valid && key_ready;
  assign in_hs     = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_mode  = out_mode_q;

`ifdef RAVAN_KEY_CHECK_EN
  logic key_error_q;
  assign key_bad   = (key == '0);
  assign key_error = key_error_q;
`else
  assign key_bad   = 1'b0;
  assign key_error = 1'b0;
`endif

  // Decrypt walks the schedule backwards and undoes each add-rotate step.
  always_comb begin
    ridx = mode_q ? cnt_q : (LAST - cnt_q);
    if (mode_q) x_d = rotl(x_q + rk_q[ridx]);
    else        x_d = rotr(x_q) - rk_q[ridx];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mode_q  <= 1'b0;
`ifdef RAVAN_KEY_CHECK_EN
      key_error_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, READY: begin
          if (key_hs) begin
            cnt_q   <= '0;
            state_q <= key_bad ? IDLE : KEYSCHED;
`ifdef RAVAN_KEY_CHECK_EN
            key_error_q <= key_bad;
`endif
          end else if (in_hs) begin
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        KEYSCHED: begin
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= READY;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        BUSY: begin
          if (cnt_q == LAST) begin
            cnt_q       <= '0;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= x_d;
            out_mode_q  <= mode_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= READY;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (key_hs) begin
      key_q <= key;
    end else if (state_q == KEYSCHED) begin
      rk_q[cnt_q] <= key_q[DATA_W-1:0] ^ DATA_W'(cnt_q);
      key_q       <= key_rot(key_q);
    end
    if (in_hs) begin
      x_q    <= in_data;
      mode_q <= in_mode;
    end else if (state_q == BUSY) begin
      x_q <= x_d;
    end
  end
endmodule

// File: tb/tb_ravan_stream_core.sv
// Bench for ravan_stream_core: random blocks scored against a queue-based reference model.
module tb_ravan_stream_core;
  localparam int DW = 64, KW = 512, R = 8, RT = 3, NW = KW / DW;

  logic          clk = 1'b0, rst = 1'b0;
  logic          key_valid = 1'b0, key_ready;
  logic [KW-1:0] key = '0;
  logic          in_valid = 1'b0, in_ready, in_mode = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid, out_ready = 1'b0, out_mode, busy, key_error;
  logic [DW-1:0] out_data;

  logic          r1_key_valid = 1'b0, r1_key_ready;
  logic [KW-1:0] r1_key = '0;
  logic          r1_in_valid = 1'b0, r1_in_ready, r1_in_mode = 1'b0;
  logic [DW-1:0] r1_in_data = '0;
  logic          r1_out_valid, r1_out_mode, r1_busy, r1_key_error;
  logic          r1_out_ready = 1'b1;
  logic [DW-1:0] r1_out_data;

  int errors = 0, checks = 0;
  logic hold_low = 1'b0;
  logic [DW:0] exp_q [$];
  logic [DW-1:0] rk_m [R];

  always #5 clk = ~clk;

  ravan_stream_core #(.DATA_W(DW), .KEY_W(KW), .ROUNDS(R), .ROT(RT)) u_dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready), .key(key),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
    .busy(busy), .key_error(key_error));

  ravan_stream_core #(.DATA_W(DW), .KEY_W(KW), .ROUNDS(1), .ROT(RT)) u_r1 (
    .clk(clk), .rst(rst), .key_valid(r1_key_valid), .key_ready(r1_key_ready), .key(r1_key),
    .in_valid(r1_in_valid), .in_ready(r1_in_ready), .in_mode(r1_in_mode), .in_data(r1_in_data),
    .out_valid(r1_out_valid), .out_ready(r1_out_ready), .out_data(r1_out_data),
    .out_mode(r1_out_mode), .busy(r1_busy), .key_error(r1_key_error));

  // Reference model: rotations as the matching half of a doubled word.
  function automatic logic [DW-1:0] rol(input logic [DW-1:0] v, input int s);
    logic [2*DW-1:0] t;
    t = {v, v} << s;
    return t[2*DW-1:DW];
  endfunction

  function automatic logic [DW-1:0] ror(input logic [DW-1:0] v, input int s);
    logic [2*DW-1:0] t;
    t = {v, v} >> s;
    return t[DW-1:0];
  endfunction

  task automatic model_sched(input logic [KW-1:0] k);
    for (int i = 0; i < R; i++) rk_m[i] = k[(i % NW)*DW +: DW] ^ DW'(i);
  endtask

  function automatic logic [DW-1:0] enc_m(input logic [DW-1:0] p);
    logic [DW-1:0] x = p;
    for (int r = 0; r < R; r++) x = rol(x + rk_m[r], RT);
    return x;
  endfunction

  function automatic logic [DW-1:0] dec_m(input logic [DW-1:0] c);
    logic [DW-1:0] x = c;
    for (int r = 0; r < R; r++) x = ror(x, RT) - rk_m[R-1-r];
    return x;
  endfunction

  function automatic logic [DW-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [KW-1:0] rand_key();
    logic [KW-1:0] k;
    for (int i = 0; i < KW/32; i++) k[i*32 +: 32] = $urandom;
    return k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", nm, act, req);
    end
  endtask

  task automatic load_key(input logic [KW-1:0] k);
    int n = 0;
    key = k;
    key_valid = 1'b1;
    @(negedge clk);
    while (!key_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk1("key_handshake_ready", key_ready, 1'b1);
    @(posedge clk);
    #1 key_valid = 1'b0;
  endtask

  task automatic wait_key_ready(output int n);
    n = 0;
    while (!key_ready && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic send_block(input logic [DW-1:0] d, input logic m, input logic [DW-1:0] e);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk1("in_handshake_timeout", in_ready, 1'b1);
      #1 in_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back({m, e});
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard monitor: every completed output handshake pops one expectation.
  always @(negedge clk) begin : monitor
    logic [DW:0] e;
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk1("unexpected_output", out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", out_data, e[DW-1:0]);
        chk1("sb_mode", out_mode, e[DW]);
      end
    end
  end

  initial begin : backpressure
    forever begin
      @(posedge clk);
      #1 out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [KW-1:0] k;
    logic [DW-1:0] p, c, d, cap;
    logic m;
    int n, e;

    rst = 1'b0;
    tick();
    tick();
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk1("rst_out_mode", out_mode, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_key_ready", key_ready, 1'b1);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_key_error", key_error, 1'b0);
    rst = 1'b1;
    tick();

    // Single-round instance: key = 1 gives rk[0] = 1.
    r1_key = KW'(1);
    r1_key_valid = 1'b1;
    @(posedge clk);
    #1 r1_key_valid = 1'b0;
    n = 0;
    while (!r1_in_ready && n < 20) begin
      tick();
      n++;
    end
    r1_in_valid = 1'b1; r1_in_mode = 1'b1; r1_in_data = '0;
    @(posedge clk);
    #1 r1_in_valid = 1'b0;
    e = 0;
    while (!r1_out_valid && e < 20) begin
      tick();
      e++;
    end
    chk("r1_enc_latency", 64'(e + 1), 64'd2);
    chk("r1_enc_data", r1_out_data, 64'h8);
    chk1("r1_enc_mode", r1_out_mode, 1'b1);
    tick();
    r1_in_valid = 1'b1; r1_in_mode = 1'b0; r1_in_data = 64'h8;
    @(posedge clk);
    #1 r1_in_valid = 1'b0;
    e = 0;
    while (!r1_out_valid && e < 20) begin
      tick();
      e++;
    end
    chk("r1_dec_data", r1_out_data, 64'h0);
    chk1("r1_dec_mode", r1_out_mode, 1'b0);

    k = rand_key();
    load_key(k);
    model_sched(k);
    wait_key_ready(n);
    chk("keysched_len", 64'(n), 64'(R));

    for (int i = 0; i < 100; i++) begin
      p = rand64();
      c = enc_m(p);
      send_block(p, 1'b1, c);
      send_block(c, 1'b0, p);
    end
    for (int i = 0; i < 20; i++) begin
      d = rand64();
      m = 1'($urandom_range(0, 1));
      send_block(d, m, m ? enc_m(d) : dec_m(d));
    end
    drain();

    // Output held in DONE under backpressure.
    hold_low = 1'b1;
    p = rand64();
    send_block(p, 1'b1, enc_m(p));
    e = 0;
    while (!out_valid && e < 50) begin
      tick();
      e++;
    end
    chk("latency", 64'(e + 1), 64'(R + 1));
    cap = out_data;
    chk("hold_first_data", out_data, enc_m(p));
    d = rand64();
    in_valid = 1'b1; in_data = d; in_mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("hold_out_valid", out_valid, 1'b1);
      chk("hold_out_data", out_data, cap);
      chk1("hold_out_mode", out_mode, 1'b1);
      chk1("hold_in_ready", in_ready, 1'b0);
    end
    hold_low = 1'b0;
    send_block(d, 1'b0, dec_m(d));
    drain();

    // Key and data offered together in READY.
    k = rand_key();
    d = rand64();
    key = k; key_valid = 1'b1;
    in_valid = 1'b1; in_data = d; in_mode = 1'b1;
    @(negedge clk);
    chk1("prio_in_ready", in_ready, 1'b0);
    chk1("prio_key_ready", key_ready, 1'b1);
    @(posedge clk);
    #1 key_valid = 1'b0;
    model_sched(k);
    wait_key_ready(n);
    chk("prio_keysched_len", 64'(n), 64'(R));
    send_block(d, 1'b1, enc_m(d));
    drain();

    // Reset in the middle of a block.
    d = rand64();
    send_block(d, 1'b1, enc_m(d));
    tick();
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_q.delete();
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk1("midrst_key_ready", key_ready, 1'b1);
    in_valid = 1'b1; in_data = d; in_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("midrst_in_ready", in_ready, 1'b0);
      chk1("midrst_no_output", out_valid, 1'b0);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    k = rand_key();
    load_key(k);
    model_sched(k);
    wait_key_ready(n);
    d = rand64();
    send_block(d, 1'b1, enc_m(d));
    drain();

`ifdef RAVAN_KEY_CHECK_EN
    load_key('0);
    chk1("zero_key_error", key_error, 1'b1);
    chk1("zero_key_in_ready", in_ready, 1'b0);
    chk1("zero_key_key_ready", key_ready, 1'b1);
    load_key(KW'(5));
    chk1("key5_error_cleared", key_error, 1'b0);
    model_sched(KW'(5));
`else
    load_key('0);
    chk1("zero_key_no_error", key_error, 1'b0);
    model_sched('0);
`endif
    wait_key_ready(n);
    chk("last_keysched_len", 64'(n), 64'(R));
    d = rand64();
    send_block(d, 1'b1, enc_m(d));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
